// File: rtl/fir_decim_buffer.sv
// Accumulate-and-dump decimator feeding a show-ahead result FIFO with drop counting.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up with saturation.
module fir_decim_buffer #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DECIM = 2,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [LOG2_DEPTH:0]   fifo_level,
    output logic [15:0]           overflow_cnt,
    input  logic                  clear_stats
);

    localparam int ACC_W = DATA_W + LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int DEPTH = 1 << LOG2_DEPTH;

    // ---------------- decimator ----------------
    logic signed [DATA_W-1:0] in_s;
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     last_sample;
    logic                     dump;
    logic [DATA_W-1:0]        result;

    assign in_s        = in_data;
    assign sum         = acc_q + ACC_W'(in_s);
    assign last_sample = (cnt_q == CNT_W'((1 << LOG2_DECIM) - 1));
    assign dump        = in_valid && last_sample;

`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'((1 << LOG2_DECIM) >> 1);
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W:0] rsum, rshift;

    always_comb begin
        rsum   = (ACC_W+1)'(sum) + RND;
        rshift = rsum >>> LOG2_DECIM;
        if (rshift > SAT_HI) begin
            result = DATA_W'(SAT_HI);
        end else if (rshift < SAT_LO) begin
            result = DATA_W'(SAT_LO);
        end else begin
            result = DATA_W'(rshift);
        end
    end
`else
    assign result = DATA_W'(sum >>> LOG2_DECIM);
`endif

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            if (last_sample) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- result FIFO ----------------
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [LOG2_DEPTH:0]   level_q, level_d;
    logic [DATA_W-1:0]     head_q, head_d;
    logic [15:0]           ovf_q, ovf_d;
    logic                  full, pop, wr_en, drop;

    assign full   = (level_q == (LOG2_DEPTH+1)'(DEPTH));
    assign pop    = (level_q != '0) && out_ready;
    assign wr_en  = dump && (!full || pop);
    assign drop   = dump && full && !pop;
    assign rd_nxt = rd_ptr_q + LOG2_DEPTH'(1);

    // The head is a separate register so it holds its last value once drained;
    // a push into a FIFO that is empty (or emptying this cycle) bypasses memory.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        ovf_d    = ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
        if (pop)   rd_ptr_d = rd_nxt;

        if (wr_en && !pop) begin
            level_d = level_q + (LOG2_DEPTH+1)'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - (LOG2_DEPTH+1)'(1);
        end

        if (pop) begin
            if (level_q > (LOG2_DEPTH+1)'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (wr_en) begin
                head_d = result;
            end
        end else if (wr_en && (level_q == '0)) begin
            head_d = result;
        end

        if (clear_stats) begin
            ovf_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid    = (level_q != '0);
    assign out_data     = head_q;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Downstream stage of the sensor FIR low-pass filter.
- Consumes one filtered signed sample per accepted cycle and applies an accumulate-and-dump decimator (boxcar average over DECIM samples).
- Buffers the decimated results in a small show-ahead FIFO, with a valid/ready output toward the packetizer/transport stage.
- Counts results dropped because the buffer was full.

Parameters:
- DATA_W, 16, sample width in and out (signed two's complement).
- LOG2_DECIM, 2, log2 of the decimation ratio; DECIM = 2**LOG2_DECIM; legal range 0..6.
- LOG2_DEPTH, 3, log2 of the FIFO depth; DEPTH = 2**LOG2_DEPTH; legal range 1..6.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is a valid filtered sample this cycle; no backpressure upstream.
- in_data  in  DATA_W  signed filtered sample.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  DATA_W  signed decimated sample at the FIFO head.
- fifo_level  out  LOG2_DEPTH+1  current FIFO occupancy, 0..DEPTH.
- overflow_cnt  out  16  count of dropped results; saturates at 0xFFFF.
- clear_stats  in  1  synchronous clear of overflow_cnt.

Behaviour:
- Reset (async, active-high) clears:
  - accumulator, sample counter, FIFO read/write pointers;
  - fifo_level=0, out_valid=0, out_data=0, overflow_cnt=0.
- Reset mid-accumulation discards the partial sum. The first result after reset covers exactly DECIM new samples.
- Accumulator width: ACC_W = DATA_W+LOG2_DECIM, sign-extended adds. It cannot overflow.
- Sample counter (0..DECIM-1) advances only when in_valid=1. Cycles with in_valid=0 are ignored entirely.
- Dump condition: in_valid=1 and counter==DECIM-1. On that edge:
  - result = (acc + sext(in_data)) >>> LOG2_DECIM, arithmetic shift;
  - result is truncated toward -inf (unless DECIM_ROUND_EN) and taken as the low DATA_W bits, which always fit;
  - the result is pushed to the FIFO;
  - acc is cleared and the counter returns to 0.
- Non-dump valid cycle: acc <= acc + sext(in_data).
- DECIM=1 (LOG2_DECIM=0): every valid sample is pushed unchanged.
- Latency: a result pushed at edge N appears on out_data with out_valid=1 after edge N if the FIFO was empty (1 cycle).
- FIFO: show-ahead, DEPTH entries. out_data always shows the head entry and holds its last value when the FIFO is empty.
  - Pop on out_valid && out_ready.
  - out_valid == (fifo_level != 0).
  - out_data is stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH; fifo_level tracks +1/-1/0 per cycle.
- Simultaneous push and pop:
  - not full: both occur, level unchanged;
  - full: both occur, no drop, level stays DEPTH;
  - empty: push only (pop is impossible because out_valid=0).
- Full and push without pop: the new result is discarded and overflow_cnt increments unless it is already 0xFFFF. FIFO contents are untouched.
- Pop while empty: ignored.
- clear_stats=1 sets overflow_cnt to 0 on the next edge.
  - If a drop happens in the same cycle, the result is 1, not 0.
- Accumulation continues regardless of FIFO state; backpressure never stalls the decimator.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: result = (sum + 2**(LOG2_DECIM-1)) >>> LOG2_DECIM, i.e. round half toward +inf. Computed in ACC_W+1 bits, then saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1]. For LOG2_DECIM=0 there is no rounding term.
- Undefined: plain arithmetic-shift truncation, no saturation logic.

Test Plan:
- Basic average: LOG2_DECIM=2; in_valid=1 with 10,20,30,40 on consecutive cycles, out_ready=1 -> one cycle after the 40 edge: out_valid=1, out_data=25; next cycle out_valid=0, fifo_level=0.
- Negative rounding: inputs -1,-1,-1,-2 (sum -5) -> out_data=-2 without the macro; out_data=-1 with FIR_DECIM_ROUND_EN. Inputs 32767 x4 -> 32767 in both builds.
- Gapped input: 10,(idle),20,(idle,idle),30,40 with in_valid low on the idle cycles -> a single result of 25, produced after the 40 edge only.
- Overflow: LOG2_DEPTH=3, out_ready=0, 9 results pushed -> fifo_level=8, overflow_cnt=1, out_data=first result. Then pulse clear_stats -> overflow_cnt=0.
- Full with simultaneous pop and push: hold the FIFO full, assert out_ready=1 on the cycle a result is pushed -> fifo_level stays 8, overflow_cnt unchanged, head advances to the second result, new result stored last.
- Reset mid-operation: 2 samples of 100, assert reset for 1 cycle, then 4,8,12,16 -> out_data=10. After reset: out_valid=0, fifo_level=0, overflow_cnt=0.
